// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider (div_seq).
package div_pkg;

  localparam int DIV_WIDTH = 32;

  // Quotient reported for any divide by zero, in both signed and unsigned mode.
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  // Magnitude of an operand. In unsigned mode the raw value is already the magnitude.
  // The most negative signed value maps onto itself, which reads correctly as an
  // unsigned magnitude of 2**(DIV_WIDTH-1).
  function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] value,
                                                   input logic                 is_signed);
    return (is_signed && value[DIV_WIDTH-1]) ? (~value + 1'b1) : value;
  endfunction

endpackage

// File: rtl/div_seq.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU. It produces one quotient bit
// per clock and has a single-pulse valid/ready handshake.
// Timing: the accept edge is edge 0. Edges 1..WIDTH are restoring steps, and edge
// WIDTH+1 applies the sign and divide-by-zero fixes. ready is high for one cycle after that.
// Optional build macro: DIV_SEQ_EARLY_OUT_EN. When it is defined, an operation with
// b==0 or |a|<|b| goes straight from IDLE to FIX, so ready pulses after edge 1.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  input  logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_count;

  // r_dvd starts as |a|. Each step shifts its top bit into the partial remainder and
  // shifts the new quotient bit in at the bottom. After WIDTH steps it holds the
  // quotient magnitude.
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_a_orig;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_b_zero;

  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_ready;

  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic             w_early;
  logic [WIDTH:0]   w_shifted;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rem_step;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_a_abs = abs_val(a, is_signed);
  assign w_b_abs = abs_val(b, is_signed);

`ifdef DIV_SEQ_EARLY_OUT_EN
  // Quotient is known to be zero (or forced for b==0), so the RUN phase can be skipped.
  assign w_early = (b == '0) || (w_a_abs < w_b_abs);
`else
  assign w_early = 1'b0;
`endif

  // One restoring step. The partial remainder is always less than the divisor, so the
  // shifted value fits in WIDTH+1 bits. When the compare succeeds, the difference fits in WIDTH bits.
  assign w_shifted  = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge       = (w_shifted >= {1'b0, r_dvs});
  assign w_diff     = w_shifted[WIDTH-1:0] - r_dvs;
  assign w_rem_step = w_ge ? w_diff : w_shifted[WIDTH-1:0];

  // Sign correction. A zero divisor overrides it in both modes and returns the original dividend.
  assign w_q_fix = r_b_zero ? DIV_ZERO_QUOT[WIDTH-1:0]
                            : (r_neg_q ? (~r_dvd + 1'b1) : r_dvd);
  assign w_r_fix = r_b_zero ? r_a_orig
                            : (r_neg_r ? (~r_rem + 1'b1) : r_rem);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: accept only in IDLE, step WIDTH times, then one fix-up cycle.
  // NOTE: w_next is given a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (valid) w_next = w_early ? FIX : RUN;
      RUN:     if (r_count == '0) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs: busy covers the whole operation and drops in the ready cycle.
  always_comb begin
    busy = (r_state != IDLE);
  end

  // Datapath: capture operands on accept, iterate in RUN, and publish results in FIX.
  // NOTE: every datapath register is reset so that an interrupted operation leaves no residue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_dvd    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_a_orig <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_quot   <= '0;
      r_remo   <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (valid) begin
            r_dvs    <= w_b_abs;
            r_a_orig <= a;
            r_b_zero <= (b == '0);
            r_neg_q  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r  <= is_signed & a[WIDTH-1];
            r_count  <= CW'(WIDTH - 1);
            if (w_early) begin
              // Early out: quotient 0, remainder |a|. FIX then restores the sign of a.
              r_dvd <= '0;
              r_rem <= w_a_abs;
            end else begin
              r_dvd <= w_a_abs;
              r_rem <= '0;
            end
          end
        end
        RUN: begin
          r_dvd   <= {r_dvd[WIDTH-2:0], w_ge};
          r_rem   <= w_rem_step;
          r_count <= r_count - 1'b1;
        end
        FIX: begin
          r_quot  <= w_q_fix;
          r_remo  <= w_r_fix;
          r_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign quotient  = r_quot;
  assign remainder = r_remo;
  assign ready     = r_ready;

endmodule
